// File: rtl/controle_leitor.sv
// Pulse-width remote-control frame decoder: leader, 32 LSB-first bits, command/complement check.
// Optional macro LEITOR_ADDR_CHECK_EN also rejects frames whose address byte and its complement disagree.
module controle_leitor #(
  parameter int unsigned T0_MIN     = 20000,
  parameter int unsigned T0_MAX     = 26000,
  parameter int unsigned T1_MIN     = 72000,
  parameter int unsigned T1_MAX     = 86000,
  parameter int unsigned LEADER_MIN = 100000,
  parameter int unsigned TIMEOUT    = 150000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sinal,
  input  logic       ack,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [17:0] T0_MIN_C     = 18'(T0_MIN);
  localparam logic [17:0] T0_MAX_C     = 18'(T0_MAX);
  localparam logic [17:0] T1_MIN_C     = 18'(T1_MIN);
  localparam logic [17:0] T1_MAX_C     = 18'(T1_MAX);
  localparam logic [17:0] LEADER_MIN_C = 18'(LEADER_MIN);
  localparam logic [17:0] TIMEOUT_C    = 18'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LEADER   = 3'd1,
    BIT_LOW  = 3'd2,
    BIT_HIGH = 3'd3,
    CHECK    = 3'd4,
    ERR      = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        sinal_q;
  logic [17:0] cnt_q, cnt_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] shift_q, shift_d;
  logic        pend_q, pend_d;
  logic [7:0]  pend_cmd_q, pend_cmd_d;
  logic [7:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;

  logic is_zero, is_one, cmd_ok, frame_ok;

  assign is_zero = (cnt_q >= T0_MIN_C) && (cnt_q <= T0_MAX_C);
  assign is_one  = (cnt_q >= T1_MIN_C) && (cnt_q <= T1_MAX_C);
  assign cmd_ok  = ((shift_q[23:16] ^ shift_q[31:24]) == 8'hFF);

`ifdef LEITOR_ADDR_CHECK_EN
  assign frame_ok = cmd_ok && ((shift_q[7:0] ^ shift_q[15:8]) == 8'hFF);
`else
  assign frame_ok = cmd_ok;
`endif

  always_comb begin
    state_d     = state_q;
    // Counter measures the current level run; it restarts at 1 on the first sample of a new level.
    cnt_d       = (sinal != sinal_q) ? 18'd1 : ((cnt_q == '1) ? cnt_q : cnt_q + 18'd1);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    pend_d      = 1'b0;
    pend_cmd_d  = pend_cmd_q;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (sinal) begin
          state_d   = LEADER;
          cnt_d     = 18'd1;
          bit_cnt_d = 6'd0;
          shift_d   = 32'd0;
        end
      end
      LEADER: begin
        if (!sinal) state_d = (cnt_q >= LEADER_MIN_C) ? BIT_LOW : IDLE;
      end
      BIT_LOW: begin
        if (sinal)                    state_d = BIT_HIGH;
        else if (cnt_d >= TIMEOUT_C)  state_d = ERR;
      end
      BIT_HIGH: begin
        if (!sinal) begin
          if (is_zero || is_one) begin
            shift_d   = {is_one, shift_q[31:1]};
            bit_cnt_d = bit_cnt_q + 6'd1;
            state_d   = (bit_cnt_q == 6'd31) ? CHECK : BIT_LOW;
          end else begin
            state_d = ERR;
          end
        end
      end
      CHECK: begin
        if (frame_ok) begin
          pend_d     = 1'b1;
          pend_cmd_d = shift_q[23:16];
          state_d    = IDLE;
        end else begin
          state_d = ERR;
        end
      end
      ERR: begin
        shift_d   = 32'd0;
        bit_cnt_d = 6'd0;
        if (!sinal) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    frame_err_d = (state_d == ERR) && (state_q != ERR);

    // An ack landing with the new key frees the slot, so the key loads instead of overrunning.
    if (pend_q && (!key_valid_q || ack)) begin
      key_code_d  = pend_cmd_q;
      key_valid_d = 1'b1;
    end else if (ack) begin
      key_valid_d = 1'b0;
    end
    overrun_d = pend_q && key_valid_q && !ack;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sinal_q     <= 1'b0;
      cnt_q       <= 18'd0;
      bit_cnt_q   <= 6'd0;
      shift_q     <= 32'd0;
      pend_q      <= 1'b0;
      pend_cmd_q  <= 8'h00;
      key_code_q  <= 8'h00;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sinal_q     <= sinal;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      pend_cmd_q  <= pend_cmd_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/controle_leitor.md
CONTROLE_LEITOR -- requirements
Module: controle_leitor

Interface
REQ-001 SHALL have parameter T0_MIN, default 20000, minimum high-pulse length in clk cycles for a 0 bit.
REQ-002 SHALL have parameter T0_MAX, default 26000, maximum high-pulse length in clk cycles for a 0 bit.
REQ-003 SHALL have parameter T1_MIN, default 72000, minimum high-pulse length in clk cycles for a 1 bit.
REQ-004 SHALL have parameter T1_MAX, default 86000, maximum high-pulse length in clk cycles for a 1 bit.
REQ-005 SHALL have parameter LEADER_MIN, default 100000, minimum leader high length in clk cycles.
REQ-006 SHALL have parameter TIMEOUT, default 150000, maximum low gap in clk cycles between pulses.
REQ-007 clk  input  1  sole clock; all logic on rising edge.
REQ-008 rst  input  1  synchronous reset, active-high.
REQ-009 sinal  input  1  demodulated line level, pre-synchronized; 1 = pulse.
REQ-010 ack  input  1  consumer acknowledge of key_code.
REQ-011 key_code  output  8  last accepted command byte.
REQ-012 key_valid  output  1  key_code holds an unacknowledged key.
REQ-013 frame_err  output  1  one-cycle pulse on a rejected frame.
REQ-014 overrun  output  1  one-cycle pulse when a valid frame is dropped.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, LEADER, BIT_LOW, BIT_HIGH, CHECK, ERR.
REQ-017 Pulse counter SHALL be 18 bits, SHALL clear on every sinal edge, and SHALL saturate at 262143 without wrapping.
REQ-018 IDLE: on sinal=1, go to LEADER with counter=1.
REQ-019 LEADER: on sinal=0, go to BIT_LOW if count>=LEADER_MIN, else go to IDLE silently.
REQ-020 BIT_LOW: on sinal=1, go to BIT_HIGH; if low count reaches TIMEOUT, go to ERR.
REQ-021 BIT_HIGH: on sinal=0, classify the count; T0_MIN..T0_MAX inclusive gives 0, T1_MIN..T1_MAX inclusive gives 1, any other count goes to ERR.
REQ-022 Classified bits SHALL shift LSB-first into a 32-bit register: bits[7:0] addr, [15:8] ~addr, [23:16] cmd, [31:24] ~cmd.
REQ-023 Bit counter SHALL count to 32; after the 32nd bit, go to CHECK, otherwise return to BIT_LOW.
REQ-024 CHECK, one cycle: if cmd XOR ~cmd == 8'hFF the frame is valid, else go to ERR; then go to IDLE.
REQ-025 Valid frame with key_valid=0: key_code<=cmd and key_valid<=1, visible 2 cycles after the clk edge that first samples sinal=0 ending bit 32.
REQ-026 Valid frame with key_valid=1 and ack=0: the frame SHALL be dropped, key_code SHALL be kept, and overrun SHALL pulse once.
REQ-027 ack=1 SHALL clear key_valid on the next edge; ack together with valid-frame completion SHALL load the new key with key_valid kept at 1 and no overrun.
REQ-028 ack while key_valid=0 SHALL be ignored.
REQ-029 ERR: frame_err SHALL pulse one cycle and the block SHALL wait until sinal=0 before entering IDLE; the shift register and bit counter SHALL clear.
REQ-030 key_code SHALL change only on key load; frame_err and overrun SHALL never both be high in the same cycle.

Reset
REQ-031 rst SHALL force IDLE and clear the counters, shift register, key_code=8'h00, key_valid=0, frame_err=0, overrun=0 and busy=0 on the next edge.
REQ-032 rst mid-frame SHALL abandon the frame with no frame_err; decoding resumes only on a fresh leader.

Configuration
REQ-033 Macro LEITOR_ADDR_CHECK_EN: when defined, CHECK SHALL additionally require addr XOR ~addr == 8'hFF, else go to ERR; when undefined, the address bytes SHALL be shifted but ignored.

Verification
REQ-034 Leader 110000 high, then 32 bits encoding addr 8'h00 and cmd 8'h45 (0 = 23000 high, 1 = 79000 high, 5000 low gaps) -> key_valid=1 and key_code=8'h45 exactly 2 cycles after the last fall.
REQ-035 Same frame but bit 20 high for 50000 cycles -> frame_err pulses once, key_valid stays 0, busy=0 after sinal low.
REQ-036 Two valid frames, cmd 8'h45 then 8'h16, with no ack -> key_code=8'h45 and one overrun pulse; then ack -> key_valid=0.
REQ-037 ack asserted in the cycle the 8'h16 frame completes -> key_code=8'h16, key_valid=1, no overrun.
REQ-038 Low gap of 150000 after bit 10 -> frame_err; rst asserted at bit 15 of the next frame -> all outputs zero, no frame_err.
REQ-039 With LEITOR_ADDR_CHECK_EN, addr byte 8'h00 and ~addr byte 8'h01 -> frame_err; without the macro -> key accepted.
